// File: rtl/fp_mult_arb_pkg.sv
// Shared sizing helpers and the round-robin search used by fp_mult_arb.
package fp_mult_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    function automatic int word_width(input int sig_w, input int exp_w);
        return sig_w + exp_w + 1;
    endfunction

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of vld at or after ptr, wrapping within the first n positions.
    function automatic rr_pick_t rr_search(input logic [MAX_REQ-1:0] vld, input int ptr, input int n);
        rr_pick_t pick;
        int       idx;
        pick = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (k < n) begin
                if (!pick.found && vld[idx[2:0]]) begin
                    pick.found = 1'b1;
                    pick.idx   = idx[2:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fp_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves past each winner.
// Grants nothing while enable is low; the pointer then holds.
module fp_rr_arb
    import fp_mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     index
);

    logic [IDW-1:0]     ptr;
    logic [MAX_REQ-1:0] vld_ext;
    rr_pick_t           pick;
    logic               unused_pick_bits;

    always_comb begin
        vld_ext = '0;
        vld_ext[NUM_REQ-1:0] = valid;
        pick  = rr_search(vld_ext, int'(ptr), NUM_REQ);
        index = pick.idx[IDW-1:0];
        grant = '0;
        if (enable && pick.found) grant[index] = 1'b1;
    end

    assign unused_pick_bits = ^pick.idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (enable && pick.found) begin
            ptr <= (int'(index) == NUM_REQ - 1) ? '0 : index + 1'b1;
        end
    end

endmodule

// File: rtl/fp_mult_arb.sv
// Round-robin front end for a shared combinational FP multiplier; 2 edges accept->res_valid.
// Grants stall only when both stages are full and res_ready is low; FP_MULT_ARB_PERF_EN adds perf_cnt.
module fp_mult_arb
    import fp_mult_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int SIG_WIDTH = 10,
    parameter int EXP_WIDTH = 8,
    localparam int W        = word_width(SIG_WIDTH, EXP_WIDTH),
    localparam int IDW      = id_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    input  logic [2:0]           rnd,
    output logic [W-1:0]         mul_a,
    output logic [W-1:0]         mul_b,
    output logic [2:0]           mul_rnd,
    input  logic [W-1:0]         mul_z,
    input  logic [7:0]           mul_status,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [W-1:0]         res_z,
    output logic [7:0]           res_status,
    output logic [IDW-1:0]       res_id,
    output logic [31:0]          perf_cnt
);

    typedef struct packed {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2:0]     rnd;
        logic [IDW-1:0] id;
    } issue_t;

    issue_t             iss;
    logic               iss_vld;
    logic               res_free;
    logic               iss_free;
    logic               arb_en;
    logic               accept;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     gnt_idx;
    logic [W-1:0]       sel_a;
    logic [W-1:0]       sel_b;

    assign res_free = !res_valid || res_ready;
    assign iss_free = !iss_vld || res_free;
    assign arb_en   = iss_free && !reset;

    fp_rr_arb #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .valid  (req_valid),
        .enable (arb_en),
        .grant  (grant),
        .index  (gnt_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iss_vld <= 1'b0;
            iss     <= '0;
        end else if (iss_free) begin
            iss_vld <= accept;
            if (accept) iss <= '{a: sel_a, b: sel_b, rnd: rnd, id: gnt_idx};
        end
    end

    assign mul_a   = iss.a;
    assign mul_b   = iss.b;
    assign mul_rnd = iss.rnd;

    // The multiplier is combinational, so its output belongs to the entry in the issue stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid  <= 1'b0;
            res_z      <= '0;
            res_status <= '0;
            res_id     <= '0;
        end else if (res_free) begin
            res_valid <= iss_vld;
            if (iss_vld) begin
                res_z      <= mul_z;
                res_status <= mul_status;
                res_id     <= iss.id;
            end
        end
    end

`ifdef FP_MULT_ARB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cnt <= '0;
        end else if (accept) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end
`else
    assign perf_cnt = '0;
`endif

endmodule
